// File: rtl/fs_serial_sub_if.sv
// Start/Busy/Done handshake and operand/result bus for fs_serial_sub.
// Bin exists only when FS_SERIAL_SUB_BORROW_IN_EN is defined.
interface fs_serial_sub_if #(
  parameter int WIDTH = 8
);
  logic             Start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
`ifdef FS_SERIAL_SUB_BORROW_IN_EN
  logic             Bin;
`endif
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Result;
  logic             Borrow;

  modport master (
    output Start,
    output A,
    output B,
`ifdef FS_SERIAL_SUB_BORROW_IN_EN
    output Bin,
`endif
    input  Busy,
    input  Done,
    input  Result,
    input  Borrow
  );

  modport slave (
    input  Start,
    input  A,
    input  B,
`ifdef FS_SERIAL_SUB_BORROW_IN_EN
    input  Bin,
`endif
    output Busy,
    output Done,
    output Result,
    output Borrow
  );
endinterface

// File: rtl/fs_serial_sub.sv
// Bit-serial WIDTH-bit subtractor: one registered full-subtractor cell.
// Define FS_SERIAL_SUB_BORROW_IN_EN to add the Bin initial-borrow input.
module fs_serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic           CLK,
  input  logic           RST,
  fs_serial_sub_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_bf;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;

  logic w_a;
  logic w_b;
  logic w_c;
  logic w_d;
  logic w_bo;
  logic w_c0;
  logic w_last;
  logic w_accept;

  assign w_a  = r_a[0];
  assign w_b  = r_b[0];
  assign w_c  = r_bf;
  assign w_d  = w_a ^ w_b ^ w_c;
  assign w_bo = (~w_a & w_b) | (~(w_a ^ w_b) & w_c);

`ifdef FS_SERIAL_SUB_BORROW_IN_EN
  assign w_c0 = bus.Bin;
`else
  assign w_c0 = 1'b0;
`endif

  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_accept = (r_state == S_IDLE) && bus.Start;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.Start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      r_done  <= (w_next == S_DONE);
    end
  end

  // Result collects LSB-first from the top, so after WIDTH shifts
  // bit 0 has reached position 0 and no stale bits remain.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
      r_bf  <= 1'b0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_a   <= bus.A;
      r_b   <= bus.B;
      r_bf  <= w_c0;
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_res <= {w_d, r_res[WIDTH-1:1]};
      r_bf  <= w_bo;
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign bus.Busy   = r_busy;
  assign bus.Done   = r_done;
  assign bus.Result = r_res;
  assign bus.Borrow = r_bf;

endmodule
